// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter for the MEM stage: shares one synchronous RAM port
// between the pipeline (P) and the debug/loader unit (D), with starvation guard and debug lock.
module dmem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              p_req_i,
    input  logic              p_we_i,
    input  logic [31:0]       p_addr_i,
    input  logic [DATA_W-1:0] p_wdata_i,
    output logic              p_gnt_o,
    output logic              p_stall_o,
    output logic              p_rvalid_o,
    output logic [DATA_W-1:0] p_rdata_o,
    output logic              p_err_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [31:0]       d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic              d_lock_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_P = 2'd1, OWN_D = 2'd2} owner_e;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    // Any nonzero bit above the RAM word-address range makes the access illegal.
    function automatic logic addr_oor(input logic [31:0] addr);
        return |addr[31:ADDR_W];
    endfunction

    state_e            state_q;
    owner_e            pend_q;
    logic              pend_oor_q;
    logic [3:0]        starve_q;
    logic              p_err_q;
    logic [DATA_W-1:0] p_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              lock_active_s;
    logic              p_gnt_s;
    logic              d_gnt_s;
    logic              p_oor_s;
    logic              d_oor_s;
    logic [DATA_W-1:0] rd_data_s;

    // Lock ends in the very cycle d_lock is seen low, so that cycle arbitrates normally.
    assign lock_active_s = (state_q == ST_LOCK) && d_lock_i;
    assign p_oor_s       = addr_oor(p_addr_i);
    assign d_oor_s       = addr_oor(d_addr_i);

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        p_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst_ni) begin
            p_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (lock_active_s) begin
            d_gnt_s = d_req_i;
        end else if ((starve_q == LIMIT_C) && d_req_i) begin
            d_gnt_s = 1'b1;
        end else if (p_req_i) begin
            p_gnt_s = 1'b1;
        end else if (d_req_i) begin
            d_gnt_s = 1'b1;
        end else begin
            p_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // RAM port follows the granted requester; out-of-range writes are suppressed.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = {ADDR_W{1'b0}};
        mem_din_o  = {DATA_W{1'b0}};
        if (p_gnt_s) begin
            mem_we_o   = p_we_i & ~p_oor_s;
            mem_addr_o = p_addr_i[ADDR_W-1:0];
            mem_din_o  = p_wdata_i;
        end else if (d_gnt_s) begin
            mem_we_o   = d_we_i & ~d_oor_s;
            mem_addr_o = d_addr_i[ADDR_W-1:0];
            mem_din_o  = d_wdata_i;
        end else begin
            mem_we_o   = 1'b0;
            mem_addr_o = {ADDR_W{1'b0}};
            mem_din_o  = {DATA_W{1'b0}};
        end
    end

    assign rd_data_s  = pend_oor_q ? {DATA_W{1'b0}} : mem_dout_i;
    assign p_gnt_o    = p_gnt_s;
    assign d_gnt_o    = d_gnt_s;
    assign p_stall_o  = p_req_i & ~p_gnt_s & rst_ni;
    assign p_rvalid_o = (pend_q == OWN_P);
    assign d_rvalid_o = (pend_q == OWN_D);
    assign p_err_o    = p_err_q;
    // RAM data arrives the cycle after the grant; the holding register keeps it afterwards.
    assign p_rdata_o  = (pend_q == OWN_P) ? rd_data_s : p_rdata_q;
    assign d_rdata_o  = (pend_q == OWN_D) ? rd_data_s : d_rdata_q;

    // Lock FSM, starvation counter, read-return tracking and held read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            pend_q     <= OWN_NONE;
            pend_oor_q <= 1'b0;
            starve_q   <= 4'd0;
            p_err_q    <= 1'b0;
            p_rdata_q  <= {DATA_W{1'b0}};
            d_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            if (lock_active_s) begin
                state_q <= ST_LOCK;
            end else if (d_gnt_s && d_lock_i) begin
                state_q <= ST_LOCK;
            end else begin
                state_q <= ST_ARB;
            end

            if (lock_active_s || d_gnt_s || !d_req_i) begin
                starve_q <= 4'd0;
            end else if (starve_q != LIMIT_C) begin
                starve_q <= starve_q + 4'd1;
            end else begin
                starve_q <= starve_q;
            end

            if (p_gnt_s && !p_we_i) begin
                pend_q     <= OWN_P;
                pend_oor_q <= p_oor_s;
            end else if (d_gnt_s && !d_we_i) begin
                pend_q     <= OWN_D;
                pend_oor_q <= d_oor_s;
            end else begin
                pend_q     <= OWN_NONE;
                pend_oor_q <= 1'b0;
            end

            p_err_q <= p_gnt_s & p_oor_s;

            case (pend_q)
                OWN_P:   p_rdata_q <= rd_data_s;
                OWN_D:   d_rdata_q <= rd_data_s;
                default: begin
                    p_rdata_q <= p_rdata_q;
                    d_rdata_q <= d_rdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              p_req, p_we, p_gnt, p_stall, p_rvalid, p_err;
    logic [31:0]       p_addr;
    logic [DATA_W-1:0] p_wdata, p_rdata;
    logic              d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout;
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
        .p_gnt_o(p_gnt), .p_stall_o(p_stall), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata),
        .p_err_o(p_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_lock_i(d_lock), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_req = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_lock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h5; p_wdata = 32'hFFFF_FFFF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6; d_wdata = 32'h0; d_lock = 1'b1;
        #3;
        n_cmp++; if (p_gnt !== 1'b0) begin n_err++; $display("FAIL rst_p_gnt: got %0b want 0", p_gnt); end
        n_cmp++; if (d_gnt !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt: got %0b want 0", d_gnt); end
        n_cmp++; if (p_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", p_stall); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 13'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if ({p_rvalid, d_rvalid, p_err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {p_rvalid, d_rvalid, p_err}); end
        n_cmp++; if (p_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h/%h want 0/0", p_rdata, d_rdata); end
        tick(); tick();
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_p_only();
        logic [31:0] pre_a [4];
        logic [31:0] pre_d [4];
        pre_a = '{32'h0, 32'h10, 32'h11, 32'h12};
        pre_d = '{32'h1234_5678, 32'hA000_0010, 32'hA000_0011, 32'hA000_0012};
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h5; p_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (p_gnt !== 1'b1 || p_stall !== 1'b0) begin n_err++; $display("FAIL ponly_wr_gnt: got gnt=%0b stall=%0b want 1/0", p_gnt, p_stall); end
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 13'h5 || mem_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ponly_wr_port: got we=%0b a=%h d=%h want 1/5/deadbeef", mem_we, mem_addr, mem_din); end
        tick();
        p_we = 1'b0;
        #1;
        n_cmp++; if (p_rvalid !== 1'b0) begin n_err++; $display("FAIL ponly_wr_norvalid: got %0b want 0", p_rvalid); end
        n_cmp++; if (p_gnt !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL ponly_rd_gnt: got gnt=%0b we=%0b want 1/0", p_gnt, mem_we); end
        tick();
        idle();
        #1;
        n_cmp++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ponly_rd_data: got v=%0b d=%h want 1/deadbeef", p_rvalid, p_rdata); end
        n_cmp++; if (p_stall !== 1'b0) begin n_err++; $display("FAIL ponly_stall: got %0b want 0", p_stall); end
        for (int i = 0; i < 4; i++) begin
            tick();
            p_req = 1'b1; p_we = 1'b1; p_addr = pre_a[i]; p_wdata = pre_d[i];
            #1;
            n_cmp++; if (mem_we !== 1'b1 || mem_din !== pre_d[i]) begin n_err++; $display("FAIL preload_%0d: got we=%0b d=%h want 1/%h", i, mem_we, mem_din, pre_d[i]); end
        end
        tick();
        idle();
        n_cmp++; if (p_rvalid !== 1'b0) begin n_err++; $display("FAIL ponly_rvalid_once: got %0b want 0", p_rvalid); end
        tick();
    endtask

    task automatic test_conflict();
        logic exp_d;
        for (int i = 0; i < 8; i++) begin
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h5;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
            exp_d = (i == 4);
            #1;
            n_cmp++; if (p_gnt !== ~exp_d || d_gnt !== exp_d) begin n_err++; $display("FAIL conflict_gnt_c%0d: got p=%0b d=%0b want p=%0b d=%0b", i, p_gnt, d_gnt, ~exp_d, exp_d); end
            n_cmp++; if (p_stall !== exp_d) begin n_err++; $display("FAIL conflict_stall_c%0d: got %0b want %0b", i, p_stall, exp_d); end
            tick();
            if (i == 4) begin
                n_cmp++; if (dut.starve_q !== 4'd0) begin n_err++; $display("FAIL conflict_starve_clr: got %0d want 0", dut.starve_q); end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_lock();
        logic [31:0] exp_rd [3];
        exp_rd = '{32'hA000_0010, 32'hA000_0011, 32'hA000_0012};
        d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 32'h10;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL lock_first_gnt: got %0b want 1", d_gnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== exp_rd[i]) begin n_err++; $display("FAIL lock_rdata_%0d: got v=%0b d=%h want 1/%h", i, d_rvalid, d_rdata, exp_rd[i]); end
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h5;
            d_req = (i < 2); d_addr = 32'h11 + 32'(i);
            #1;
            n_cmp++; if (p_gnt !== 1'b0 || p_stall !== 1'b1) begin n_err++; $display("FAIL lock_p_blocked_%0d: got gnt=%0b stall=%0b want 0/1", i, p_gnt, p_stall); end
            n_cmp++; if (d_gnt !== (i < 2)) begin n_err++; $display("FAIL lock_d_gnt_%0d: got %0b want %0b", i, d_gnt, (i < 2)); end
        end
        tick();
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL lock_rvalid_count: got %0b want 0", d_rvalid); end
        d_lock = 1'b0;
        #1;
        n_cmp++; if (p_gnt !== 1'b1 || p_stall !== 1'b0) begin n_err++; $display("FAIL lock_release: got gnt=%0b stall=%0b want 1/0", p_gnt, p_stall); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_oor();
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h0000_2000; p_wdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (p_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 13'h0) begin n_err++; $display("FAIL oor_wr_port: got gnt=%0b we=%0b a=%h want 1/0/0", p_gnt, mem_we, mem_addr); end
        tick();
        n_cmp++; if (p_err !== 1'b1 || p_rvalid !== 1'b0) begin n_err++; $display("FAIL oor_wr_err: got err=%0b v=%0b want 1/0", p_err, p_rvalid); end
        p_we = 1'b0;
        tick();
        n_cmp++; if (p_rvalid !== 1'b1 || p_rdata !== 32'h0 || p_err !== 1'b1) begin n_err++; $display("FAIL oor_rd: got v=%0b d=%h err=%0b want 1/0/1", p_rvalid, p_rdata, p_err); end
        p_addr = 32'h0;
        tick();
        idle();
        n_cmp++; if (p_err !== 1'b0 || p_rvalid !== 1'b1 || p_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL oor_ram_intact: got err=%0b v=%0b d=%h want 0/1/12345678", p_err, p_rvalid, p_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 32'h11;
        #1;
        n_cmp++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_gnt: got %0b want 1", d_gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (d_gnt !== 1'b0) begin n_err++; $display("FAIL midrst_gnt_off: got %0b want 0", d_gnt); end
        tick();
        n_cmp++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rvalid: got v=%0b d=%h want 0/0", d_rvalid, d_rdata); end
        n_cmp++; if (dut.state_q !== 1'b0) begin n_err++; $display("FAIL midrst_state: got %0b want 0", dut.state_q); end
        idle();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (d_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_no_late_rvalid: got %0b want 0", d_rvalid); end
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h5;
        #1;
        n_cmp++; if (p_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_p_gnt: got %0b want 1", p_gnt); end
        tick();
        idle();
        n_cmp++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL midrst_p_read: got v=%0b d=%h want 1/deadbeef", p_rvalid, p_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'h10;
        tick();
        n_cmp++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hA000_0010 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_err++; $display("FAIL b2b_c1: got pv=%0b pd=%h dv=%0b dd=%h want 1/a0000010/0/0", p_rvalid, p_rdata, d_rvalid, d_rdata); end
        p_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h11;
        tick();
        n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_0011 || p_rvalid !== 1'b0 || p_rdata !== 32'hA000_0010) begin n_err++; $display("FAIL b2b_c2: got dv=%0b dd=%h pv=%0b pd=%h want 1/a0000011/0/a0000010", d_rvalid, d_rdata, p_rvalid, p_rdata); end
        d_req = 1'b0; p_req = 1'b1; p_addr = 32'h12;
        tick();
        idle();
        n_cmp++; if (p_rvalid !== 1'b1 || p_rdata !== 32'hA000_0012 || d_rvalid !== 1'b0 || d_rdata !== 32'hA000_0011) begin n_err++; $display("FAIL b2b_c3: got pv=%0b pd=%h dv=%0b dd=%h want 1/a0000012/0/a0000011", p_rvalid, p_rdata, d_rvalid, d_rdata); end
        tick();
        n_cmp++; if (p_rvalid !== 1'b0 || p_rdata !== 32'hA000_0012) begin n_err++; $display("FAIL b2b_hold: got v=%0b d=%h want 0/a0000012", p_rvalid, p_rdata); end
    endtask

    initial begin
        test_reset();
        test_p_only();
        test_conflict();
        test_lock();
        test_oor();
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Owns the single data-memory port of the MIPS MEM stage and shares it between two requesters: the pipeline MEM stage (P) and the debug/loader unit (D), which is used for UART program load and memory dump.
- Drives the synchronous single-port RAM, which has 1-cycle read latency.
- Routes read data back to whichever requester issued the read.
- Raises a stall to the pipeline whenever P is denied.
- Contains a starvation guard and a debug lock state machine.

Parameters:
ADDR_W, 13, RAM word-address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive denied cycles of D before D is forced a slot (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
p_req  in  1  pipeline access request (MEM stage M-signal or load)
p_we  in  1  pipeline write enable
p_addr  in  32  pipeline word address
p_wdata  in  DATA_W  pipeline write data
p_gnt  out  1  pipeline access granted this cycle
p_stall  out  1  freeze IF/ID/EX/MEM pipeline registers
p_rvalid  out  1  pipeline read data valid
p_rdata  out  DATA_W  pipeline read data
p_err  out  1  pipeline address out of range
d_req  in  1  debug access request
d_we  in  1  debug write enable
d_addr  in  32  debug word address
d_wdata  in  DATA_W  debug write data
d_lock  in  1  debug requests exclusive ownership
d_gnt  out  1  debug access granted this cycle
d_rvalid  out  1  debug read data valid
d_rdata  out  DATA_W  debug read data
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_din  out  DATA_W  RAM write data
mem_dout  in  DATA_W  RAM read data (registered inside the RAM, valid the cycle after the address)

Behaviour:
- Reset (reset=0, asynchronous) forces the following; all outputs are 0 while reset is held:
  - state=ARB, starve_cnt=0, pending owner=NONE
  - p_rvalid/d_rvalid/p_err=0, p_rdata/d_rdata=0
- Grant (combinational from the current state and requests):
  - Only one of p_gnt/d_gnt may be high in a cycle.
  - mem_we/mem_addr/mem_din come from the granted requester.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0.
- ARB state priority:
  - If starve_cnt==STARVE_LIMIT and d_req, grant D.
  - Else if p_req, grant P.
  - Else if d_req, grant D.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle d_req=1 and d_gnt=0.
  - Clears when d_gnt=1 or d_req=0.
- Address range: an address is out of range if bits [31:ADDR_W] are nonzero.
  - A granted out-of-range access has mem_we forced to 0.
  - It returns rdata=0 with rvalid next cycle for reads.
  - p_err pulses for 1 cycle (next cycle) for P; D errors are silently zeroed.
  - mem_addr always carries addr[ADDR_W-1:0].
- Read latency:
  - A granted read in cycle N registers the owner (P or D).
  - In N+1 the owner's rvalid=1 for exactly one cycle and its rdata is loaded from mem_dout (or 0 if out of range).
  - The non-owner's rdata holds its previous value.
- Writes complete in the grant cycle and never assert rvalid.
- Back-to-back accesses are allowed:
  - A new grant in N+1 while rvalid is being returned is legal.
  - Throughput is one access per cycle.
- p_stall = p_req & ~p_gnt (combinational).
  - p_stall is 0 when p_req=0.
- Lock state machine (ARB, LOCK):
  - ARB->LOCK when d_gnt=1 and d_lock=1.
  - In LOCK, only D may be granted, on any cycle with d_req, and p_gnt=0. p_stall follows p_req.
  - LOCK->ARB in the first cycle d_lock=0 is sampled; the grant decision in that cycle already uses ARB rules.
  - starve_cnt is held at 0 in LOCK.
- d_lock asserted without d_gnt has no effect.
- Reset mid-operation: a pending rvalid is cancelled (never emitted) and the lock is released.

Test Plan:
- P-only read: write p_addr=5, p_wdata=0xDEADBEEF (p_gnt=1); then read p_addr=5 -> p_rvalid=1 one cycle after grant, p_rdata=0xDEADBEEF, p_stall stays 0.
- Conflict: p_req and d_req held high together for 8 cycles, STARVE_LIMIT=4 -> P granted cycles 0-3, D granted cycle 4 (P stalled exactly that cycle), P granted cycles 5-7; starve_cnt back to 0 after the D grant.
- Lock burst: D issues a lock read of addr 0x10 (d_lock=1), then d_addr 0x11, 0x12 while p_req=1 -> p_gnt=0 and p_stall=1 for all 3 cycles; d_rvalid pulses 3 times with the correct data; P is granted the cycle d_lock drops.
- Out-of-range: P write to addr 0x0000_2000 (bit 13 set) -> mem_we=0, RAM at 0x0000 unchanged, p_err=1 next cycle; a P read of the same address -> p_rdata=0, p_rvalid=1.
- Reset mid-read: a D read is granted in cycle N and reset=0 is asserted before N+1's edge -> d_rvalid never pulses, state=ARB, and after release a P read works normally.
- Back-to-back alternating owners: P read A, D read B, P read C on consecutive cycles -> rvalids alternate each cycle with the correct rdata routing; each non-owner's rdata is unchanged.
